// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, RISC-V B/H/W sizing with sign/zero extension.
// Latency: READ_LATENCY / WRITE_LATENCY edges from acceptance to rsp_valid_o (1 for rejected requests).
// Backpressure: response held until rsp_ready_i; req_ready_o low whenever the FSM is not idle or in reset.
module data_mem_responder #(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AB    = ADDR_WIDTH + 2;   // byte-address bits that reach the array

    // Counter preloads are latency-1; legal latencies are 1..15 so they fit in 4 bits.
    localparam logic [3:0] RD_CNT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_CNT = 4'(WRITE_LATENCY - 1);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [2:0]     size_q, size_d;
    logic [AB-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;

    logic [31:0]    mem_q [DEPTH];

    logic           req_err;
    logic           mem_we;
    logic [3:0]     mem_be;
    logic [31:0]    mem_wword;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_val;

    // Idle-only acceptance; depends on state and reset alone, never on req_valid_i or rsp_ready_i.
    assign req_ready_o = reset_i && (state_q == IDLE);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Classify the incoming request: unknown size, unsigned store, misalignment or out-of-range address.
    always_comb begin
        req_err = 1'b0;
        if (!(req_size_i inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU}))
            req_err = 1'b1;
        if (req_we_i && (req_size_i == SZ_BU || req_size_i == SZ_HU))
            req_err = 1'b1;
        if ((req_size_i == SZ_H || req_size_i == SZ_HU) && req_addr_i[0])
            req_err = 1'b1;
        if ((req_size_i == SZ_W) && (req_addr_i[1:0] != 2'b00))
            req_err = 1'b1;
        if ((req_addr_i >> AB) != 32'd0)
            req_err = 1'b1;
    end

    // Lane selection and extension of the latched load address against the current array contents.
    always_comb begin
        rd_word  = mem_q[addr_q[AB-1:2]];
        rd_byte  = rd_word[8*addr_q[1:0] +: 8];
        rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        case (size_q)
            SZ_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    load_val = {{16{rd_half[15]}}, rd_half};
            SZ_W:    load_val = rd_word;
            SZ_BU:   load_val = {24'd0, rd_byte};
            SZ_HU:   load_val = {16'd0, rd_half};
            default: load_val = 32'd0;
        endcase
    end

    // Byte enables and lane-replicated write data for a legal store.
    always_comb begin
        mem_be    = 4'b0000;
        mem_wword = wdata_q;
        case (size_q)
            SZ_B: begin
                mem_be    = 4'b0001 << addr_q[1:0];
                mem_wword = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                mem_wword = {2{wdata_q[15:0]}};
            end
            SZ_W: begin
                mem_be    = 4'b1111;
                mem_wword = wdata_q;
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wword = wdata_q;
            end
        endcase
    end

    // Next-state logic: latch and classify in IDLE, count down in BUSY, hold the response in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    addr_d  = req_addr_i[AB-1:0];
                    wdata_d = req_wdata_i;
                    err_d   = req_err;
                    if (req_err)       cnt_d = 4'd0;
                    else if (req_we_i) cnt_d = WR_CNT;
                    else               cnt_d = RD_CNT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? 32'd0 : load_val;
                    // Commit shares the edge that raises rsp_valid; a reset on that edge aborts it.
                    mem_we      = we_q && !err_q && reset_i;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane writes into the array; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i])
                mem_q[addr_q[AB-1:2]][8*i +: 8] <= mem_wword[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default-latency instance plus a WRITE_LATENCY=4 instance.
// Latency is measured in clock edges from acceptance to rsp_valid.
// Backpressure and reset-abort are exercised with explicit cycle-level stimulus.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        sel;          // 0 = default instance, 1 = WRITE_LATENCY=4 instance
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    assign req_ready = sel ? b_req_ready : a_req_ready;
    assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    data_mem_responder dut (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .req_valid_i (req_valid & ~sel),
        .req_ready_o (a_req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (a_rsp_rdata),
        .rsp_err_o   (a_rsp_err)
    );

    data_mem_responder #(.WRITE_LATENCY(4)) dut_wl4 (
        .clk_i       (clk),
        .reset_i     (rst_n),
        .req_valid_i (req_valid & sel),
        .req_ready_o (b_req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (b_rsp_rdata),
        .rsp_err_o   (b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; returns data, error flag and latency in edges.
    task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);             // acceptance edge
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!rsp_valid && lat < 40);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);             // handshake edge
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    logic [31:0] held_rdata;
    int          guard;

    initial begin
        sel = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 3'b010; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Word store then load
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lt);
        chk("sw_lat", 32'(lt), 32'd1);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        xact(1'b0, 3'b010, 32'h10, 32'd0, rd, er, lt);
        chk("lw_lat", 32'(lt), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);

        // Byte/half extension
        xact(1'b1, 3'b010, 32'h20, 32'h8081F0F1, rd, er, lt);
        xact(1'b0, 3'b000, 32'h23, 32'd0, rd, er, lt);
        chk("lb_23", rd, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 32'h23, 32'd0, rd, er, lt);
        chk("lbu_23", rd, 32'h00000080);
        xact(1'b0, 3'b001, 32'h22, 32'd0, rd, er, lt);
        chk("lh_22", rd, 32'hFFFF8081);
        xact(1'b0, 3'b101, 32'h20, 32'd0, rd, er, lt);
        chk("lhu_20", rd, 32'h0000F0F1);
        xact(1'b0, 3'b000, 32'h20, 32'd0, rd, er, lt);
        chk("lb_20", rd, 32'hFFFFFFF1);

        // Partial stores
        xact(1'b1, 3'b010, 32'h30, 32'h00000000, rd, er, lt);
        xact(1'b1, 3'b000, 32'h31, 32'hFFFFFFAB, rd, er, lt);
        chk("sb_err", 32'(er), 32'd0);
        xact(1'b1, 3'b001, 32'h32, 32'hFFFF1234, rd, er, lt);
        chk("sh_err", 32'(er), 32'd0);
        xact(1'b0, 3'b010, 32'h30, 32'd0, rd, er, lt);
        chk("partial_lw", rd, 32'h1234AB00);

        // Errors: seed the targeted words first
        xact(1'b1, 3'b010, 32'h00, 32'h01234567, rd, er, lt);
        xact(1'b1, 3'b010, 32'h04, 32'h89ABCDEF, rd, er, lt);

        xact(1'b0, 3'b010, 32'h02, 32'd0, rd, er, lt);
        chk("err_lw_mis_err", 32'(er), 32'd1);
        chk("err_lw_mis_rdata", rd, 32'd0);
        chk("err_lw_mis_lat", 32'(lt), 32'd1);

        xact(1'b1, 3'b001, 32'h05, 32'h0000FFFF, rd, er, lt);
        chk("err_sh_mis_err", 32'(er), 32'd1);
        chk("err_sh_mis_rdata", rd, 32'd0);
        chk("err_sh_mis_lat", 32'(lt), 32'd1);
        xact(1'b0, 3'b010, 32'h04, 32'd0, rd, er, lt);
        chk("err_sh_word_unchanged", rd, 32'h89ABCDEF);

        xact(1'b0, 3'b011, 32'h00, 32'd0, rd, er, lt);
        chk("err_size011_err", 32'(er), 32'd1);
        chk("err_size011_rdata", rd, 32'd0);
        chk("err_size011_lat", 32'(lt), 32'd1);

        xact(1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, rd, er, lt);
        chk("err_sbu_err", 32'(er), 32'd1);

        xact(1'b1, 3'b010, 32'h1000, 32'hFFFFFFFF, rd, er, lt);
        chk("err_sw_range_err", 32'(er), 32'd1);
        xact(1'b0, 3'b010, 32'h1000, 32'd0, rd, er, lt);
        chk("err_lw_range_err", 32'(er), 32'd1);
        chk("err_lw_range_rdata", rd, 32'd0);
        chk("err_lw_range_lat", 32'(lt), 32'd1);
        xact(1'b0, 3'b010, 32'h00, 32'd0, rd, er, lt);
        chk("err_word0_unchanged", rd, 32'h01234567);
        chk("err_word0_err", 32'(er), 32'd0);

        // Highest in-range word is still legal
        xact(1'b1, 3'b010, 32'hFFC, 32'h5A5A1234, rd, er, lt);
        chk("top_sw_err", 32'(er), 32'd0);
        xact(1'b0, 3'b010, 32'hFFC, 32'd0, rd, er, lt);
        chk("top_lw_rdata", rd, 32'h5A5A1234);

        // Backpressure: response held while a second request waits
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(posedge clk);
            #1 guard++;
        end
        chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
        held_rdata = rsp_rdata;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_hold_%0d", i), rsp_rdata, held_rdata);
            chk($sformatf("bp_err_%0d", i), 32'(rsp_err), 32'd0);
            chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_rdata", rsp_rdata, 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Reset abort on the WRITE_LATENCY=4 instance
        sel = 1'b1;
        xact(1'b1, 3'b010, 32'h40, 32'h11111111, rd, er, lt);
        chk("wl4_sw_lat", 32'(lt), 32'd4);
        chk("wl4_sw_err", 32'(er), 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h22222222;
        @(posedge clk);             // accepted, count = 3
        #1 req_valid = 1'b0;
        @(posedge clk);             // count = 2
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);             // reset edge while still in BUSY
        @(negedge clk);
        chk("abort_rst_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_response", 32'(rsp_valid), 32'd0);
        xact(1'b0, 3'b010, 32'h40, 32'd0, rd, er, lt);
        chk("abort_word_unchanged", rd, 32'h11111111);
        chk("wl4_lw_lat", 32'(lt), 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and applies RISC-V byte/half/word sizing (funct3 encoding) with sign or zero extension. It returns a response after a configurable latency and flags misaligned, out-of-range and illegal-size accesses. It replaces the zero-latency data memory so the datapath can be exercised against realistic, stallable memory timing.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2: edges from request acceptance to rsp_valid rising for a legal load; legal range 1..15.
- WRITE_LATENCY, 1: same, for a legal store; legal range 1..15.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE and while reset is high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid && req_ready: latch we, size, addr and wdata, then classify the request.
- **Error classification.** A request is an error if any of these holds:
  - size not in {000, 001, 010, 100, 101};
  - a store with size 100 or 101;
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - addr[31:ADDR_WIDTH+2]≠0.
- **Latency selection.** Error uses latency 1. Legal load uses READ_LATENCY. Legal store uses WRITE_LATENCY. Go to BUSY with count=latency-1.
- **BUSY.** If count≠0, decrement. If count==0, go to RESP on the next edge, registering rsp_valid=1, rsp_rdata and rsp_err.
- **Store commit.** A legal store writes memory on that same edge:
  - B: lane addr[1:0] gets wdata[7:0].
  - H: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - W: all four lanes.
  - Other lanes are unchanged. Errors never modify memory.
- **Load result.** Read the word at addr[ADDR_WIDTH+1:2], select the lane(s) and extend:
  - B/H: sign-extend.
  - BU/HU: zero-extend.
  - W: as-is.
- **RESP.** Hold rsp_valid, rsp_rdata and rsp_err stable until an edge with rsp_ready=1. On that edge go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- **Reset.**
  - reset=0 at an edge forces IDLE and sets rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready is 0 while reset=0.
  - Memory array is not cleared.
  - A store still in BUSY is aborted and never commits.
- **Accepted, not queued.** While the FSM is not in IDLE, req_valid is ignored. The requester must hold the request until req_ready.

## Timing
- Acceptance edge E0.
- rsp_valid is visible after edge E0+L, where L = the latency selected above.
- With rsp_ready held high, the response handshakes at E0+L+1 and IDLE returns after it. The next acceptance is at the earliest at E0+L+2, so peak throughput is one transaction per L+2 cycles.
- Store memory update happens at E0+L. A load accepted after that response sees the new data.
- req_ready is combinational from state and reset only. It has no combinational path from req_valid or rsp_ready.
- All of rsp_* are registered outputs.

## Test plan
- **Reset:** reset=0 for 2 cycles, then 1.
  - During reset: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
  - After reset: req_ready=1.
- **Word store then load:** SW 0xDEADBEEF @0x10, then LW @0x10.
  - SW: rsp_valid exactly 1 edge after acceptance, rsp_err=0, rdata=0.
  - LW: rdata=0xDEADBEEF, rsp_valid exactly 2 edges after acceptance.
- **Byte/half extension:** SW 0x8081F0F1 @0x20, then LB @0x23, LBU @0x23, LH @0x22, LHU @0x20 →
  - LB @0x23: 0xFFFFFF80
  - LBU @0x23: 0x00000080
  - LH @0x22: 0xFFFF8081
  - LHU @0x20: 0x0000F0F1
- **Partial stores:** SW 0 @0x30, SB 0xAB @0x31, SH 0x1234 @0x32, then LW @0x30 → 0x1234AB00.
- **Errors:** LW @0x02, SH @0x05, size 011 @0x00, LW @(2^(ADDR_WIDTH+2)) →
  - each: rsp_err=1, rdata=0, rsp_valid 1 edge after acceptance;
  - a following LW of the targeted word shows it unchanged.
- **Backpressure and reset abort:**
  - Hold rsp_ready=0 for 5 cycles on a load response: rsp_* stay stable and req_ready=0 while a second req_valid is held.
  - Assert reset while a store with WRITE_LATENCY=4 is in BUSY: the target word is unchanged afterwards.
